// File: rtl/memif_pkg.sv
// Shared widths, burst limit and sequencer state encoding for the SDRAM local-port arbiter.
package memif_pkg;

    localparam int unsigned DEF_ADDR_W  = 24;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_BURST_W = 4;
    localparam int unsigned MAX_BURST   = 8;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WR      = 3'd2,
        ST_RD_CMD  = 3'd3,
        ST_RD_WAIT = 3'd4
    } state_t;

endpackage

// File: rtl/memif_rr_arb2.sv
// Two-way round-robin pick; the pointer remembers the last winner so a contested pick alternates.
module memif_rr_arb2 (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_any_c,
    output logic       gnt_sel_c
);

    logic last_q;

    // Both requesting: the side not served last wins; otherwise whoever is asking.
    always_comb begin
        gnt_any_c = |req;
        gnt_sel_c = (&req) ? ~last_q : req[1];
    end

    // Reset to 1 so requester 0 wins the first contested pick.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (advance && gnt_any_c) begin
            last_q <= gnt_sel_c;
        end
    end

endmodule

// File: rtl/memif_arb2.sv
// Two-requester burst arbiter/sequencer in front of the SDRAM controller local port.
// One whole burst in flight at a time; read data is steered back to the burst owner.
module memif_arb2
    import memif_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned BURST_W = DEF_BURST_W
) (
    input  logic                  ref_clk,
    input  logic                  reset,
    input  logic                  local_init_done,

    input  logic                  rq0_req,
    input  logic                  rq0_we,
    input  logic [ADDR_W-1:0]     rq0_addr,
    input  logic [BURST_W-1:0]    rq0_len,
    input  logic [DATA_W-1:0]     rq0_wdata,
    output logic                  rq0_gnt,
    output logic                  rq0_wdata_rd,
    output logic [DATA_W-1:0]     rq0_rdata,
    output logic                  rq0_rdata_valid,
    output logic                  rq0_done,

    input  logic                  rq1_req,
    input  logic                  rq1_we,
    input  logic [ADDR_W-1:0]     rq1_addr,
    input  logic [BURST_W-1:0]    rq1_len,
    input  logic [DATA_W-1:0]     rq1_wdata,
    output logic                  rq1_gnt,
    output logic                  rq1_wdata_rd,
    output logic [DATA_W-1:0]     rq1_rdata,
    output logic                  rq1_rdata_valid,
    output logic                  rq1_done,

    input  logic                  avl_ready,
    output logic                  avl_write_req,
    output logic                  avl_read_req,
    output logic                  avl_burstbegin,
    output logic [ADDR_W-1:0]     avl_addr,
    output logic [BURST_W-1:0]    avl_size,
    output logic [DATA_W-1:0]     avl_wdata,
    output logic [DATA_W/8-1:0]   avl_be,
    input  logic [DATA_W-1:0]     avl_rdata,
    input  logic                  avl_rdata_valid,
    output logic                  err
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_t               state_q, state_d;
    logic                 owner_q;
    logic [BURST_W-1:0]   len_m1_q;
    logic [BURST_W-1:0]   beat_q;

    logic                 gnt_any_c, gnt_sel_c;
    logic                 grant_c;
    logic                 sel_we_c;
    logic [ADDR_W-1:0]    sel_addr_c;
    logic [BURST_W-1:0]   sel_len_c, sel_len_m1_c;
    logic                 wr_xfer_c, rd_beat_c, last_beat_c, fin_c;

    memif_rr_arb2 u_rr (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .req       ({rq1_req, rq0_req}),
        .advance   (state_q == ST_IDLE),
        .gnt_any_c (gnt_any_c),
        .gnt_sel_c (gnt_sel_c)
    );

    // Winner's request fields, with the burst length normalised to 1..MAX_BURST.
    always_comb begin
        sel_we_c   = gnt_sel_c ? rq1_we   : rq0_we;
        sel_addr_c = gnt_sel_c ? rq1_addr : rq0_addr;
        sel_len_c  = gnt_sel_c ? rq1_len  : rq0_len;
        if (sel_len_c == '0) begin
            sel_len_m1_c = '0;
        end else if (sel_len_c > BURST_W'(MAX_BURST)) begin
            sel_len_m1_c = BURST_W'(MAX_BURST - 1);
        end else begin
            sel_len_m1_c = sel_len_c - BURST_W'(1);
        end
    end

    always_comb begin
        grant_c     = (state_q == ST_IDLE) && gnt_any_c;
        wr_xfer_c   = avl_write_req && avl_ready;
        rd_beat_c   = (state_q == ST_RD_WAIT) && avl_rdata_valid;
        last_beat_c = (beat_q == len_m1_q);
        fin_c       = (wr_xfer_c || rd_beat_c) && last_beat_c;
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    if (local_init_done)                  state_d = ST_IDLE;
            ST_IDLE:    if (gnt_any_c)                        state_d = sel_we_c ? ST_WR : ST_RD_CMD;
            ST_WR:      if (wr_xfer_c && last_beat_c)         state_d = ST_IDLE;
            ST_RD_CMD:  if (avl_ready)                        state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (avl_rdata_valid && last_beat_c)   state_d = ST_IDLE;
            default:                                          state_d = ST_INIT;
        endcase
    end

    // Registered command/response outputs, burst context and beat counting.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            owner_q         <= 1'b0;
            len_m1_q        <= '0;
            beat_q          <= '0;
            rq0_gnt         <= 1'b0;
            rq1_gnt         <= 1'b0;
            rq0_done        <= 1'b0;
            rq1_done        <= 1'b0;
            rq0_rdata       <= '0;
            rq1_rdata       <= '0;
            rq0_rdata_valid <= 1'b0;
            rq1_rdata_valid <= 1'b0;
            avl_write_req   <= 1'b0;
            avl_read_req    <= 1'b0;
            avl_burstbegin  <= 1'b0;
            avl_addr        <= '0;
            avl_size        <= '0;
            avl_be          <= '0;
            err             <= 1'b0;
        end else begin
            rq0_gnt         <= grant_c && !gnt_sel_c;
            rq1_gnt         <= grant_c &&  gnt_sel_c;
            rq0_done        <= fin_c && !owner_q;
            rq1_done        <= fin_c &&  owner_q;
            rq0_rdata_valid <= rd_beat_c && !owner_q;
            rq1_rdata_valid <= rd_beat_c &&  owner_q;
            if (rd_beat_c && !owner_q) rq0_rdata <= avl_rdata;
            if (rd_beat_c &&  owner_q) rq1_rdata <= avl_rdata;

            // Stray read data is never forwarded, only flagged.
            err <= err || (avl_rdata_valid && (state_q != ST_RD_WAIT));

            if (grant_c) begin
                owner_q  <= gnt_sel_c;
                avl_addr <= sel_addr_c;
                len_m1_q <= sel_len_m1_c;
                avl_size <= sel_len_m1_c + BURST_W'(1);
                beat_q   <= '0;
            end else if (wr_xfer_c || rd_beat_c) begin
                beat_q   <= beat_q + BURST_W'(1);
            end else if ((state_q == ST_RD_CMD) && avl_ready) begin
                beat_q   <= '0;
            end

            avl_write_req  <= (state_d == ST_WR);
            avl_read_req   <= (state_d == ST_RD_CMD);
            avl_be         <= (state_d == ST_WR) ? {BE_W{1'b1}} : {BE_W{1'b0}};
            // Burst-begin holds until the first write beat is accepted or the read command leaves.
            avl_burstbegin <= (state_d == ST_RD_CMD) ||
                              ((state_d == ST_WR) && (grant_c || (avl_burstbegin && !wr_xfer_c)));
        end
    end

    // Write data is first-word-fall-through from the owner; popping follows the accepted beat.
    assign avl_wdata    = avl_write_req ? (owner_q ? rq1_wdata : rq0_wdata) : '0;
    assign rq0_wdata_rd = wr_xfer_c && !owner_q;
    assign rq1_wdata_rd = wr_xfer_c &&  owner_q;

endmodule
